// File: rtl/sd_ppln_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sd_ppln_pkg
// Description : Shared defaults and helpers for the sd_pipeline_delay_rstn
//               register pipeline and its stage cell.
// Revision    : 1.0 - initial release
// ============================================================================
package sd_ppln_pkg;

    localparam int SD_PPLN_DEF_WIDTH   = 32;
    localparam int SD_PPLN_DEF_LATENCY = 4;

    localparam int SD_PPLN_MAX_WIDTH   = 1024;
    localparam int SD_PPLN_MAX_LATENCY = 16;

    // A stage can take a new beat when it is empty or its content moves on.
    function automatic logic stage_rdy(input logic v, input logic next_rdy);
        return ~v | next_rdy;
    endfunction

endpackage : sd_ppln_pkg
`default_nettype wire

// File: rtl/sd_ppln_stage.sv
`default_nettype none
// ============================================================================
// Module      : sd_ppln_stage
// Description : One valid/data register of the delay pipeline with
//               combinational ready chaining. Define SD_PPLN_DATA_RESET_EN to
//               clear the data register on reset.
// Revision    : 1.0 - initial release
// ============================================================================
module sd_ppln_stage
    import sd_ppln_pkg::*;
#(
    parameter int WIDTH = SD_PPLN_DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             i_gated,
    input  logic             i_prev_v,
    input  logic [WIDTH-1:0] i_prev_data,
    input  logic             i_next_rdy,
    output logic             o_v,
    output logic [WIDTH-1:0] o_data,
    output logic             o_rdy
);

    logic             r_v;
    logic [WIDTH-1:0] r_data;
    logic             w_en;

    assign o_rdy  = stage_rdy(r_v, i_next_rdy);
    assign w_en   = o_rdy & ~i_gated;
    assign o_v    = r_v;
    assign o_data = r_data;

    // Reset is checked first so it wins over the clock-gate freeze.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_v <= 1'b0;
        end else if (w_en) begin
            r_v <= i_prev_v;
        end
    end

`ifdef SD_PPLN_DATA_RESET_EN
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_data <= '0;
        end else if (w_en) begin
            r_data <= i_prev_data;
        end
    end
`else
    always_ff @(posedge clk) begin
        if (w_en) begin
            r_data <= i_prev_data;
        end
    end
`endif

endmodule : sd_ppln_stage
`default_nettype wire

// File: rtl/sd_pipeline_delay_rstn.sv
`default_nettype none
// ============================================================================
// Module      : sd_pipeline_delay_rstn
// Description : Fixed-latency srdy/drdy delay pipeline with bubble collapsing
//               and a clock-gate freeze. Optional macro SD_PPLN_DATA_RESET_EN
//               resets the data registers to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module sd_pipeline_delay_rstn
    import sd_ppln_pkg::*;
#(
    parameter int width   = SD_PPLN_DEF_WIDTH,
    parameter int latency = SD_PPLN_DEF_LATENCY
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             cfg_is_clk_gated,
    input  logic             in_srdy,
    output logic             in_drdy,
    input  logic [width-1:0] in_data,
    output logic             out_srdy,
    input  logic             out_drdy,
    output logic [width-1:0] out_data
);

    if (latency == 0) begin : g_wire
        assign out_srdy = in_srdy & ~cfg_is_clk_gated;
        assign in_drdy  = out_drdy & ~cfg_is_clk_gated;
        assign out_data = in_data;

        logic w_unused;
        assign w_unused = &{1'b0, clk, rstn};
    end else begin : g_pipe
        // Index 0 is the upstream side, index latency the downstream side.
        logic [latency:0]            w_vc;
        logic [latency:0]            w_rc;
        logic [latency:0][width-1:0] w_dc;

        assign w_vc[0]       = in_srdy;
        assign w_dc[0]       = in_data;
        assign w_rc[latency] = out_drdy;

        for (genvar i = 0; i < latency; i++) begin : g_stage
            sd_ppln_stage #(
                .WIDTH (width)
            ) u_stage (
                .clk         (clk),
                .rstn        (rstn),
                .i_gated     (cfg_is_clk_gated),
                .i_prev_v    (w_vc[i]),
                .i_prev_data (w_dc[i]),
                .i_next_rdy  (w_rc[i+1]),
                .o_v         (w_vc[i+1]),
                .o_data      (w_dc[i+1]),
                .o_rdy       (w_rc[i])
            );
        end

        assign in_drdy  = w_rc[0] & ~cfg_is_clk_gated;
        assign out_srdy = w_vc[latency] & ~cfg_is_clk_gated;
        assign out_data = w_dc[latency];
    end

endmodule : sd_pipeline_delay_rstn
`default_nettype wire

// File: tb/tb_sd_pipeline_delay_rstn.sv
`default_nettype none
// ============================================================================
// Module      : tb_sd_pipeline_delay_rstn
// Description : Directed self-checking bench for sd_pipeline_delay_rstn at
//               latencies 4, 3, 2 and 0.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sd_pipeline_delay_rstn;

    logic clk;
    logic rstn;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // latency 4
    logic        a_gated, a_in_srdy, a_in_drdy, a_out_srdy, a_out_drdy;
    logic [31:0] a_in_data, a_out_data;
    // latency 3
    logic        b_gated, b_in_srdy, b_in_drdy, b_out_srdy, b_out_drdy;
    logic [31:0] b_in_data, b_out_data;
    // latency 2
    logic        c_gated, c_in_srdy, c_in_drdy, c_out_srdy, c_out_drdy;
    logic [31:0] c_in_data, c_out_data;
    // latency 0
    logic        d_gated, d_in_srdy, d_in_drdy, d_out_srdy, d_out_drdy;
    logic [31:0] d_in_data, d_out_data;

    sd_pipeline_delay_rstn #(.width(32), .latency(4)) u_dut_l4 (
        .clk(clk), .rstn(rstn), .cfg_is_clk_gated(a_gated),
        .in_srdy(a_in_srdy), .in_drdy(a_in_drdy), .in_data(a_in_data),
        .out_srdy(a_out_srdy), .out_drdy(a_out_drdy), .out_data(a_out_data));

    sd_pipeline_delay_rstn #(.width(32), .latency(3)) u_dut_l3 (
        .clk(clk), .rstn(rstn), .cfg_is_clk_gated(b_gated),
        .in_srdy(b_in_srdy), .in_drdy(b_in_drdy), .in_data(b_in_data),
        .out_srdy(b_out_srdy), .out_drdy(b_out_drdy), .out_data(b_out_data));

    sd_pipeline_delay_rstn #(.width(32), .latency(2)) u_dut_l2 (
        .clk(clk), .rstn(rstn), .cfg_is_clk_gated(c_gated),
        .in_srdy(c_in_srdy), .in_drdy(c_in_drdy), .in_data(c_in_data),
        .out_srdy(c_out_srdy), .out_drdy(c_out_drdy), .out_data(c_out_data));

    sd_pipeline_delay_rstn #(.width(32), .latency(0)) u_dut_l0 (
        .clk(clk), .rstn(rstn), .cfg_is_clk_gated(d_gated),
        .in_srdy(d_in_srdy), .in_drdy(d_in_drdy), .in_data(d_in_data),
        .out_srdy(d_out_srdy), .out_drdy(d_out_drdy), .out_data(d_out_data));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; checks run on the falling edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Directed vectors for the stall/drain test (latency 4)
    // columns: in_srdy, in_data, out_drdy, exp in_drdy, exp out_srdy, exp out_data
    logic [0:12]       st_srdy = 13'b1111_1111_0000_0;
    logic [0:12][31:0] st_data = '{32'h10, 32'h11, 32'h12, 32'h13, 32'h14, 32'h14, 32'h14,
                                   32'h15, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    logic [0:12]       st_drdy = 13'b0000_0011_1111_1;
    logic [0:12]       ex_irdy = 13'b1111_0011_1111_1;
    logic [0:12]       ex_ov   = 13'b0000_1111_1111_0;
    logic [0:12][31:0] ex_od   = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h10, 32'h10, 32'h10,
                                   32'h11, 32'h12, 32'h13, 32'h14, 32'h15, 32'h0};

    initial begin
        rstn = 1'b0;
        {a_gated, a_in_srdy, a_out_drdy, a_in_data} = '0;
        {b_gated, b_in_srdy, b_out_drdy, b_in_data} = '0;
        {c_gated, c_in_srdy, c_out_drdy, c_in_data} = '0;
        {d_gated, d_in_srdy, d_out_drdy, d_in_data} = '0;
        next_cycle();
        next_cycle();
        rstn = 1'b1;
        @(negedge clk);
        check("rst_l4_out_srdy", {63'd0, a_out_srdy}, 64'd0);
        check("rst_l4_in_drdy",  {63'd0, a_in_drdy},  64'd1);
        check("rst_l3_out_srdy", {63'd0, b_out_srdy}, 64'd0);
        check("rst_l2_out_srdy", {63'd0, c_out_srdy}, 64'd0);
`ifdef SD_PPLN_DATA_RESET_EN
        check("rst_l4_out_data", {32'd0, a_out_data}, 64'd0);
`endif
        next_cycle();

        // Latency 4: three back-to-back beats appear 4 cycles after they enter.
        a_out_drdy = 1'b1;
        for (int k = 0; k < 9; k++) begin
            a_in_srdy = (k < 3);
            a_in_data = (k < 3) ? 32'(k + 1) : 32'h0;
            @(negedge clk);
            check($sformatf("lat4_v_c%0d", k), {63'd0, a_out_srdy}, {63'd0, (k >= 4 && k <= 6)});
            if (k >= 4 && k <= 6)
                check($sformatf("lat4_d_c%0d", k), {32'd0, a_out_data}, 64'(k - 3));
            next_cycle();
        end

        // Latency 4: downstream stall fills all stages, then drains in order.
        for (int k = 0; k < 13; k++) begin
            a_in_srdy  = st_srdy[k];
            a_in_data  = st_data[k];
            a_out_drdy = st_drdy[k];
            @(negedge clk);
            check($sformatf("stall_irdy_c%0d", k), {63'd0, a_in_drdy},  {63'd0, ex_irdy[k]});
            check($sformatf("stall_ov_c%0d", k),   {63'd0, a_out_srdy}, {63'd0, ex_ov[k]});
            if (ex_ov[k])
                check($sformatf("stall_od_c%0d", k), {32'd0, a_out_data}, {32'd0, ex_od[k]});
            next_cycle();
        end

        // Latency 4: continuous stream, one beat per cycle, never back-pressured.
        a_out_drdy = 1'b1;
        for (int k = 0; k < 14; k++) begin
            a_in_srdy = (k < 10);
            a_in_data = 32'h100 + 32'(k);
            @(negedge clk);
            if (k < 10)
                check($sformatf("thru_irdy_c%0d", k), {63'd0, a_in_drdy}, 64'd1);
            check($sformatf("thru_ov_c%0d", k), {63'd0, a_out_srdy}, {63'd0, (k >= 4)});
            if (k >= 4)
                check($sformatf("thru_od_c%0d", k), {32'd0, a_out_data}, 64'h100 + 64'(k - 4));
            next_cycle();
        end
        a_in_srdy = 1'b0;

        // Latency 3: reset with three beats in flight discards all of them.
        b_out_drdy = 1'b1;
        for (int k = 0; k < 3; k++) begin
            b_in_srdy = 1'b1;
            b_in_data = 32'h21 + 32'(k);
            next_cycle();
        end
        b_in_srdy  = 1'b0;
        b_out_drdy = 1'b0;
        @(negedge clk);
        check("l3_pre_rst_ov", {63'd0, b_out_srdy}, 64'd1);
        check("l3_pre_rst_od", {32'd0, b_out_data}, 64'h21);
        rstn = 1'b0;
        next_cycle();
        rstn       = 1'b1;
        b_out_drdy = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check($sformatf("l3_post_rst_ov_c%0d", k), {63'd0, b_out_srdy}, 64'd0);
`ifdef SD_PPLN_DATA_RESET_EN
            check($sformatf("l3_post_rst_od_c%0d", k), {32'd0, b_out_data}, 64'd0);
`endif
            next_cycle();
        end
        check("l3_post_rst_irdy", {63'd0, b_in_drdy}, 64'd1);

        // Latency 2: clock gate freezes two in-flight beats, which then resume.
        c_out_drdy = 1'b0;
        for (int k = 0; k < 2; k++) begin
            c_in_srdy = 1'b1;
            c_in_data = 32'h31 + 32'(k);
            @(negedge clk);
            check($sformatf("gate_fill_irdy_c%0d", k), {63'd0, c_in_drdy}, 64'd1);
            next_cycle();
        end
        c_gated    = 1'b1;
        c_out_drdy = 1'b1;
        c_in_data  = 32'h99;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check($sformatf("gate_irdy_c%0d", k), {63'd0, c_in_drdy},  64'd0);
            check($sformatf("gate_ov_c%0d", k),   {63'd0, c_out_srdy}, 64'd0);
            next_cycle();
        end
        c_gated   = 1'b0;
        c_in_srdy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("ungate_ov_c%0d", k), {63'd0, c_out_srdy}, {63'd0, (k < 2)});
            if (k < 2)
                check($sformatf("ungate_od_c%0d", k), {32'd0, c_out_data}, 64'h31 + 64'(k));
            next_cycle();
        end

        // Latency 2: reset wins over the clock gate.
        c_out_drdy = 1'b0;
        c_in_srdy  = 1'b1;
        c_in_data  = 32'h41;
        next_cycle();
        c_in_srdy = 1'b0;
        c_gated   = 1'b1;
        rstn      = 1'b0;
        next_cycle();
        c_gated = 1'b0;
        rstn    = 1'b1;
        @(negedge clk);
        check("gate_rst_ov0",  {63'd0, c_out_srdy}, 64'd0);
        check("gate_rst_irdy", {63'd0, c_in_drdy},  64'd1);
        next_cycle();
        @(negedge clk);
        check("gate_rst_ov1", {63'd0, c_out_srdy}, 64'd0);
        next_cycle();

        // Latency 0: pure wires.
        d_in_srdy  = 1'b1;
        d_in_data  = 32'hA5;
        d_out_drdy = 1'b1;
        @(negedge clk);
        check("l0_ov",   {63'd0, d_out_srdy}, 64'd1);
        check("l0_od",   {32'd0, d_out_data}, 64'hA5);
        check("l0_irdy", {63'd0, d_in_drdy},  64'd1);
        next_cycle();
        d_out_drdy = 1'b0;
        d_in_data  = 32'h5A;
        @(negedge clk);
        check("l0_stall_irdy", {63'd0, d_in_drdy}, 64'd0);
        check("l0_od2",        {32'd0, d_out_data}, 64'h5A);
        next_cycle();
        d_gated    = 1'b1;
        d_out_drdy = 1'b1;
        @(negedge clk);
        check("l0_gate_ov",   {63'd0, d_out_srdy}, 64'd0);
        check("l0_gate_irdy", {63'd0, d_in_drdy},  64'd0);
        next_cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_sd_pipeline_delay_rstn
`default_nettype wire
